// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a 16x oversampling baud generator,
// start-bit validation and a small receive FIFO on a valid/ready stream.
//
// Ports:
//   hclk        system clock, rising edge
//   hreset      synchronous active-high reset
//   baud_div    hclk cycles per oversample tick (0 behaves as 1)
//   uart_rxd    asynchronous serial input, idles high
//   rx_data     FIFO head byte
//   rx_valid    FIFO not empty
//   rx_ready    consumer pop (pop = rx_valid & rx_ready)
//   fifo_level  current FIFO occupancy, 0..FIFO_DEPTH
//   frame_err   1-cycle pulse when a stop bit is sampled low
//   overrun     1-cycle pulse when a good byte is dropped on a full FIFO
//   rx_busy     receiver FSM is not idle
module uart_rx_fifo #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LVL_W      = 3
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             uart_rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             frame_err,
  output logic             overrun,
  output logic             rx_busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  // Registers
  logic             sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       os_cnt_q, os_cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             brk_q, brk_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Combinational helpers
  logic             rxd_s;
  logic [DIV_W-1:0] div_max_c;
  logic             tick_c;
  logic             push_c;
  logic             pop_c;
  logic             full_c;
  logic             wr_en_c;

  assign rxd_s = sync2_q;

  // Tick generator: counter parked at 0 in IDLE; >= keeps it safe if baud_div
  // shrinks mid-frame.
  assign div_max_c = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick_c    = (state_q != S_IDLE) && (div_cnt_q >= div_max_c);
  assign div_cnt_d = (state_q == S_IDLE) ? '0 :
                     (tick_c ? '0 : div_cnt_q + DIV_W'(1));

  // State register and datapath registers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      brk_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      sync1_q     <= uart_rxd;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      brk_q       <= brk_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      if (wr_en_c) mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = tick_c ? os_cnt_q + 4'd1 : os_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    brk_d     = brk_q;
    unique case (state_q)
      S_IDLE: begin
        os_cnt_d  = '0;
        bit_idx_d = '0;
        if (rxd_s) begin
          brk_d = 1'b0;
        end else if (brk_q) begin
          // Line never returned high after a frame error: time out break frames
          state_d = S_BREAK;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_c && (os_cnt_q == 4'd7)) begin
          if (!rxd_s) begin
            state_d   = S_DATA;
            os_cnt_d  = '0;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick_c && (os_cnt_q == 4'd15)) begin
          shreg_d = {rxd_s, shreg_q[7:1]};
          if (bit_idx_q == 4'd7) begin
            state_d  = S_STOP;
            os_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick_c && (os_cnt_q == 4'd15)) begin
          state_d = S_IDLE;
          if (!rxd_s) brk_d = 1'b1;
        end
      end
      S_BREAK: begin
        if (rxd_s) begin
          state_d = S_IDLE;
        end else if (tick_c && (os_cnt_q == 4'd15)) begin
          bit_idx_d = (bit_idx_q == 4'd9) ? '0 : bit_idx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: push request and error pulse source
  always_comb begin
    push_c      = 1'b0;
    frame_err_d = 1'b0;
    if (tick_c && (os_cnt_q == 4'd15)) begin
      if (state_q == S_STOP) begin
        push_c      = rxd_s;
        frame_err_d = !rxd_s;
      end else if ((state_q == S_BREAK) && (bit_idx_q == 4'd9) && !rxd_s) begin
        frame_err_d = 1'b1;
      end
    end
  end

  // FIFO control: a pop at full frees the slot the push lands in
  assign pop_c     = rx_valid && rx_ready;
  assign full_c    = (level_q == LVL_W'(FIFO_DEPTH));
  assign wr_en_c   = push_c && (!full_c || pop_c);
  assign overrun_d = push_c && full_c && !pop_c;
  assign wr_ptr_d  = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d  = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_comb begin
    level_d = level_q;
    unique case ({wr_en_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  assign rx_data    = mem_q[rd_ptr_q];
  assign rx_valid   = (level_q != '0);
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: serial frames driven bit by bit,
// outputs compared #1 after the rising edge against hand-computed values.
module tb_uart_rx_fifo;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [15:0] baud_div;
  logic        uart_rxd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  fifo_level;
  logic        frame_err;
  logic        overrun;
  logic        rx_busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;

  uart_rx_fifo #(.DIV_W(16), .FIFO_DEPTH(4), .LVL_W(3)) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .baud_div   (baud_div),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  always #5 hclk = ~hclk;

  // Cycle counter, pulse counters and rx_valid rise timestamp
  always @(posedge hclk) begin
    cyc        <= cyc + 1;
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic send_bit(input logic v, input int bpc);
    uart_rxd = v;
    wait_cyc(bpc);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bpc);
    send_bit(1'b0, bpc);
    for (int i = 0; i < 8; i++) send_bit(b[i], bpc);
    send_bit(stop, bpc);
    uart_rxd = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int fe0, ov0, start_cyc;
    logic [7:0] seq [4];

    // Reset values
    hreset   = 1'b1;
    baud_div = 16'd4;
    uart_rxd = 1'b1;
    rx_ready = 1'b0;
    wait_cyc(5);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    hreset = 1'b0;
    wait_cyc(10);
    chk("idle_busy", 32'(rx_busy), 32'd0);

    // Basic byte at 64 hclk/bit; push lands 611 cycles after the start edge
    fe0 = fe_cnt; ov0 = ov_cnt;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 64);
    wait_cyc(64);
    chk("b1_valid", 32'(rx_valid), 32'd1);
    chk("b1_data", 32'(rx_data), 32'hA5);
    chk("b1_level", 32'(fifo_level), 32'd1);
    chk("b1_ferr", 32'(fe_cnt - fe0), 32'd0);
    chk("b1_ovr", 32'(ov_cnt - ov0), 32'd0);
    chk_rng("b1_latency", rise_cyc - start_cyc, 600, 616);
    pop_chk("b1_pop", 8'hA5);
    chk("b1_empty", 32'(rx_valid), 32'd0);

    // FIFO fill and overrun
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 64);
    wait_cyc(64);
    chk("fill_level", 32'(fifo_level), 32'd4);
    chk("fill_ovr", 32'(ov_cnt - ov0), 32'd1);
    chk("fill_ferr", 32'(fe_cnt - fe0), 32'd0);
    pop_chk("fill_pop1", 8'h01);
    pop_chk("fill_pop2", 8'h02);
    pop_chk("fill_pop3", 8'h03);
    pop_chk("fill_pop4", 8'h04);
    chk("fill_empty", 32'(rx_valid), 32'd0);
    chk("fill_level0", 32'(fifo_level), 32'd0);

    // Frame error, then recovery with a good byte
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 64);
    wait_cyc(128);
    chk("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    chk("fe_level", 32'(fifo_level), 32'd0);
    chk("fe_busy", 32'(rx_busy), 32'd0);
    send_frame(8'h7E, 1'b1, 64);
    wait_cyc(64);
    chk("fe_next_level", 32'(fifo_level), 32'd1);
    chk("fe_next_ferr", 32'(fe_cnt - fe0), 32'd1);
    pop_chk("fe_next_data", 8'h7E);

    // Glitch rejection: 16 hclk low pulse
    fe0 = fe_cnt;
    uart_rxd = 1'b0;
    wait_cyc(16);
    chk("gl_busy_hi", 32'(rx_busy), 32'd1);
    uart_rxd = 1'b1;
    wait_cyc(192);
    chk("gl_busy_lo", 32'(rx_busy), 32'd0);
    chk("gl_level", 32'(fifo_level), 32'd0);
    chk("gl_ferr", 32'(fe_cnt - fe0), 32'd0);

    // Simultaneous push and pop at full
    ov0 = ov_cnt;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b1, 64);
    wait_cyc(64);
    chk("pp_full", 32'(fifo_level), 32'd4);
    fork
      send_frame(8'h99, 1'b1, 64);
      begin
        wait_cyc(610);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
      end
    join
    wait_cyc(64);
    chk("pp_level", 32'(fifo_level), 32'd4);
    chk("pp_ovr", 32'(ov_cnt - ov0), 32'd0);
    pop_chk("pp_pop1", 8'h22);
    pop_chk("pp_pop2", 8'h33);
    pop_chk("pp_pop3", 8'h44);
    pop_chk("pp_pop4", 8'h99);
    chk("pp_empty", 32'(rx_valid), 32'd0);

    // Reset mid-frame flushes FIFO and aborts the frame
    send_frame(8'h33, 1'b1, 64);
    wait_cyc(64);
    chk("mr_pre_level", 32'(fifo_level), 32'd1);
    send_bit(1'b0, 64);
    send_bit(1'b1, 64);
    send_bit(1'b0, 64);
    send_bit(1'b1, 64);
    uart_rxd = 1'b0;
    wait_cyc(32);
    chk("mr_busy_pre", 32'(rx_busy), 32'd1);
    fe0 = fe_cnt; ov0 = ov_cnt;
    hreset   = 1'b1;
    uart_rxd = 1'b1;
    wait_cyc(3);
    chk("mr_busy", 32'(rx_busy), 32'd0);
    chk("mr_level", 32'(fifo_level), 32'd0);
    chk("mr_valid", 32'(rx_valid), 32'd0);
    chk("mr_data", 32'(rx_data), 32'd0);
    hreset = 1'b0;
    wait_cyc(200);
    chk("mr_ferr", 32'(fe_cnt - fe0), 32'd0);
    chk("mr_ovr", 32'(ov_cnt - ov0), 32'd0);
    chk("mr_busy_post", 32'(rx_busy), 32'd0);

    // baud_div=0 behaves as 1: 16 hclk/bit, push 155 cycles after start edge
    baud_div  = 16'd0;
    wait_cyc(2);
    start_cyc = cyc;
    send_frame(8'h5A, 1'b1, 16);
    wait_cyc(32);
    chk("bd0_level", 32'(fifo_level), 32'd1);
    chk_rng("bd0_latency", rise_cyc - start_cyc, 150, 160);
    pop_chk("bd0_data", 8'h5A);
    chk("bd0_empty", 32'(rx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
